// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the load/store path and dmem_responder.
//   req_valid/req_ready : request handshake (requester holds the request until accepted)
//   req_we/addr/wdata/wmask/func3 : store enable, byte address, unshifted store data,
//                         decoder write mask, RV32I funct3
//   rsp_valid/rsp_rdata/rsp_err : one-cycle response pulse, extended load data, error flag
// master = requester side, slave = responder side.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, req_func3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, req_func3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's load/store path.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high (memory array is not reset)
//   bus  : dmem_if.slave -- request handshake in, one-cycle response out
// Flow: IDLE accepts a request, WAIT burns WAIT_CYCLES cycles, RESP pulses rsp_valid.
// The store commit and the load read both happen on the edge entering RESP;
// rsp_rdata/rsp_err are registered on that edge and held until the next response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;

  // captured request
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wmask;
  logic [2:0]  cap_f3;

  // effective request: with WAIT_CYCLES=0 the commit edge is also the accept
  // edge, so the live bus fields are used while still in IDLE
  logic        e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wmask;
  logic [2:0]  e_f3;

  logic        ready_c, rsp_valid_c, commit;
  logic        err_c, oor, f3_bad, misal;
  logic [3:0]  lane, wr_be;
  logic [31:0] wr_data, rd_word, bsel, hsel, load_data;
  logic [IW-1:0] idx;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    rsp_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          if (WAIT_CYCLES > 0) state_d = WAIT;
          else                 state_d = RESP;
        end
      end
      WAIT: if (cnt_q == CNT_LAST) state_d = RESP;
      RESP: begin
        rsp_valid_c = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // reset drops any pending request and cuts a response in flight
    if (rst) begin
      state_d = IDLE;
      ready_c = 1'b0;
    end
  end

  assign commit = (state_d == RESP) && (state_q != RESP);

  // ---------------- wait counter ----------------
  always_ff @(posedge clk) begin
    if (rst)                 cnt_q <= '0;
    else if (state_q == WAIT) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    else                     cnt_q <= '0;
  end

  // ---------------- request capture ----------------
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.req_valid) begin
      cap_we    <= bus.req_we;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
      cap_wmask <= bus.req_wmask;
      cap_f3    <= bus.req_func3;
    end
  end

  always_comb begin
    if (state_q == IDLE) begin
      e_we = bus.req_we;  e_addr = bus.req_addr;  e_wdata = bus.req_wdata;
      e_wmask = bus.req_wmask;  e_f3 = bus.req_func3;
    end else begin
      e_we = cap_we;  e_addr = cap_addr;  e_wdata = cap_wdata;
      e_wmask = cap_wmask;  e_f3 = cap_f3;
    end
  end

  // ---------------- checks, lane steering ----------------
  assign idx = e_addr[IW+1:2];
  // full address compare: high bits are checked, never wrapped
  assign oor = ({2'b00, e_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    f3_bad  = 1'b0;
    misal   = 1'b0;
    lane    = 4'b0000;
    wr_data = e_wdata;
    case (e_f3)
      3'b000: begin
        lane    = 4'b0001 << e_addr[1:0];
        wr_data = {4{e_wdata[7:0]}};
      end
      3'b001: begin
        misal   = e_addr[0];
        lane    = 4'b0011 << {e_addr[1], 1'b0};
        wr_data = {2{e_wdata[15:0]}};
      end
      3'b010: begin
        misal = (e_addr[1:0] != 2'b00);
        lane  = 4'b1111;
      end
      3'b100: f3_bad = e_we;
      3'b101: begin
        f3_bad = e_we;
        misal  = e_addr[0];
      end
      default: f3_bad = 1'b1;
    endcase
  end

  assign err_c = oor | f3_bad | misal;
  // a zero mask is a silent no-op, not an error
  assign wr_be = lane & e_wmask;

  // ---------------- load extraction ----------------
  assign rd_word = mem[idx];
  assign bsel    = rd_word >> {e_addr[1:0], 3'b000};
  assign hsel    = rd_word >> {e_addr[1], 4'b0000};

  always_comb begin
    case (e_f3)
      3'b000:  load_data = {{24{bsel[7]}}, bsel[7:0]};
      3'b100:  load_data = {24'h0, bsel[7:0]};
      3'b001:  load_data = {{16{hsel[15]}}, hsel[15:0]};
      3'b101:  load_data = {16'h0, hsel[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // ---------------- memory array (no reset) ----------------
  always_ff @(posedge clk) begin
    if (commit && e_we && !err_c) begin
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= err_c;
      rdata_q <= (err_c || e_we) ? 32'h0 : load_data;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (WAIT_CYCLES = 0, 1, 3) share the request
// wires; the ones not under test are held in reset so they ignore them.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, rst3;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic [2:0]  req_func3;

  dmem_if if0 ();
  dmem_if if1 ();
  dmem_if if3 ();

  assign if0.req_valid = req_valid;  assign if0.req_we = req_we;
  assign if0.req_addr  = req_addr;   assign if0.req_wdata = req_wdata;
  assign if0.req_wmask = req_wmask;  assign if0.req_func3 = req_func3;
  assign if1.req_valid = req_valid;  assign if1.req_we = req_we;
  assign if1.req_addr  = req_addr;   assign if1.req_wdata = req_wdata;
  assign if1.req_wmask = req_wmask;  assign if1.req_func3 = req_func3;
  assign if3.req_valid = req_valid;  assign if3.req_we = req_we;
  assign if3.req_addr  = req_addr;   assign if3.req_wdata = req_wdata;
  assign if3.req_wmask = req_wmask;  assign if3.req_func3 = req_func3;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

  // outputs of the responder under test
  int          sel;
  logic        ready_s, rspv_s, err_s;
  logic [31:0] rdata_s;

  always_comb begin
    case (sel)
      0:       begin ready_s = if0.req_ready; rspv_s = if0.rsp_valid; rdata_s = if0.rsp_rdata; err_s = if0.rsp_err; end
      3:       begin ready_s = if3.req_ready; rspv_s = if3.rsp_valid; rdata_s = if3.rsp_rdata; err_s = if3.rsp_err; end
      default: begin ready_s = if1.req_ready; rspv_s = if1.rsp_valid; rdata_s = if1.rsp_rdata; err_s = if1.rsp_err; end
    endcase
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // one full transaction; lat = edges from accept edge to first sample with rsp_valid
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input logic [2:0] f3,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_wmask = wmask; req_func3 = f3;
    for (int i = 0; i < 20 && !ready_s; i++) @(negedge clk);
    if (!ready_s) check("ready_timeout", 32'(ready_s), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rspv_s && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = rdata_s;
    err   = err_s;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        seen;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; req_func3 = '0;
    sel = 1;

    // ---- reset, WAIT_CYCLES=1 ----
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready_s), 32'd0);
    check("rst_rspv",  32'(rspv_s),  32'd0);
    check("rst_rdata", rdata_s,      32'h0);
    check("rst_err",   32'(err_s),   32'd0);
    rst1 = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready_s), 32'd1);
    check("post_rst_rspv",  32'(rspv_s),  32'd0);

    // ---- SW / LW ----
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, rd, er, lat);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'h0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 3'b010, rd, er, lat);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_lat", 32'(lat), 32'd1);
    check("lw_ready_in_resp", 32'(ready_s), 32'd0);

    // ---- SB then byte/word loads ----
    do_req(1'b1, 32'h13, 32'h000000A5, 4'hF, 3'b000, rd, er, lat);
    check("sb_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h13, 32'h0, 4'hF, 3'b000, rd, er, lat);
    check("lb_rdata", rd, 32'hFFFFFFA5);
    do_req(1'b0, 32'h13, 32'h0, 4'hF, 3'b100, rd, er, lat);
    check("lbu_rdata", rd, 32'h000000A5);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 3'b010, rd, er, lat);
    check("lw_after_sb", rd, 32'hA5ADBEEF);
    do_req(1'b0, 32'h12, 32'h0, 4'hF, 3'b001, rd, er, lat);
    check("lh_hi_rdata", rd, 32'hFFFFA5AD);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 3'b101, rd, er, lat);
    check("lhu_lo_rdata", rd, 32'h0000BEEF);

    // ---- errors and boundaries ----
    do_req(1'b0, 32'h12, 32'h0, 4'hF, 3'b010, rd, er, lat);
    check("lw_mis_err", 32'(er), 32'd1);
    check("lw_mis_rdata", rd, 32'h0);
    do_req(1'b1, 32'h11, 32'h00001111, 4'hF, 3'b001, rd, er, lat);
    check("sh_mis_err", 32'(er), 32'd1);
    do_req(1'b1, 32'h10, 32'h01020304, 4'hF, 3'b011, rd, er, lat);
    check("st_f3_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 3'b110, rd, er, lat);
    check("ld_f3_err", 32'(er), 32'd1);
    // SH to upper half with mask only on the lower lanes: silent no-op
    do_req(1'b1, 32'h12, 32'h00001234, 4'b0011, 3'b001, rd, er, lat);
    check("sh_mask0_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 3'b010, rd, er, lat);
    check("word10_unchanged", rd, 32'hA5ADBEEF);
    do_req(1'b0, 32'h400, 32'h0, 4'hF, 3'b010, rd, er, lat);
    check("lw_oor_err", 32'(er), 32'd1);
    check("lw_oor_rdata", rd, 32'h0);
    do_req(1'b0, 32'h3FC, 32'h0, 4'hF, 3'b010, rd, er, lat);
    check("lw_last_word_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h80000010, 32'h0, 4'hF, 3'b010, rd, er, lat);
    check("lw_high_addr_err", 32'(er), 32'd1);

    // ---- reset mid-op, WAIT_CYCLES=3 ----
    @(negedge clk);
    rst1 = 1'b1; rst3 = 1'b0; sel = 3;
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b010, rd, er, lat);
    check("w3_sw_lat", 32'(lat), 32'd3);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h12345678; req_wmask = 4'hF; req_func3 = 3'b010;
    for (int i = 0; i < 20 && !ready_s; i++) @(negedge clk);
    @(posedge clk);             // accept edge
    @(negedge clk);             // first WAIT cycle
    req_valid = 1'b0;
    seen = rspv_s;
    @(negedge clk);             // second WAIT cycle
    seen |= rspv_s;
    rst3 = 1'b1;
    repeat (2) begin @(negedge clk); seen |= rspv_s; end
    rst3 = 1'b0;
    repeat (6) begin @(negedge clk); seen |= rspv_s; end
    check("midop_no_rsp", 32'(seen), 32'd0);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 3'b010, rd, er, lat);
    check("midop_mem_kept", rd, 32'hCAFEF00D);

    // ---- WAIT_CYCLES=0, back-to-back ----
    @(negedge clk);
    rst3 = 1'b1; rst0 = 1'b0; sel = 0;
    do_req(1'b1, 32'h0, 32'h11111111, 4'hF, 3'b010, rd, er, lat);
    check("w0_sw_lat", 32'(lat), 32'd0);
    do_req(1'b1, 32'h4, 32'h22222222, 4'hF, 3'b010, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_func3 = 3'b010;
    for (int i = 0; i < 20 && !ready_s; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("b2b_rsp1_valid", 32'(rspv_s), 32'd1);
    check("b2b_rsp1_ready", 32'(ready_s), 32'd0);
    check("b2b_rsp1_rdata", rdata_s, 32'h11111111);
    req_addr = 32'h4;
    @(negedge clk);
    check("b2b_gap_valid", 32'(rspv_s), 32'd0);
    check("b2b_gap_ready", 32'(ready_s), 32'd1);
    @(negedge clk);
    check("b2b_rsp2_valid", 32'(rspv_s), 32'd1);
    check("b2b_rsp2_rdata", rdata_s, 32'h22222222);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_pulse_end", 32'(rspv_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the core's load/store path. It consumes the store-enable, write-mask and funct3 information the decoder emits, and answers each request with load data or a store acknowledgement.
- Multi-cycle request/response handshake with a configurable number of wait states.
- Handles byte-lane steering, load sign/zero extension, misalignment and out-of-range detection.
- Sits between the execute stage (address from the ALU, store data from rs2) and the write-back mux.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array; word index is addr[31:2].
- WAIT_CYCLES, 1: wait states between accept and response; 0 is legal.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, unshifted, in low bits
- req_wmask  input  4  write mask from decoder; 4'b1111 = all lanes permitted
- req_func3  input  3  RV32I load/store funct3
- rsp_valid  output  1  response valid, one-cycle pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, req_ready 0 while rst is high and 1 on the first cycle after, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0.
- Memory array is not reset.
- FSM states and transitions:
  - IDLE: req_ready = 1. When req_valid is high, capture we/addr/wdata/wmask/func3. Go to WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: req_ready = 0. Counter runs from 0 to WAIT_CYCLES-1, then go to RESP.
  - RESP: req_ready = 0, rsp_valid = 1 for exactly one cycle, then go to IDLE.
- Latency: with the accept edge at t0, rsp_valid is high in the cycle after edge t0+WAIT_CYCLES. Throughput is one request per WAIT_CYCLES+2 cycles.
- Requests presented outside IDLE are ignored. The requester must hold them until accepted.
- Commit/read timing: the store commit and the load read both occur on the edge entering RESP. rsp_rdata and rsp_err are registered on that edge and held stable through RESP. They keep their last values in IDLE, but are meaningful only while rsp_valid is high.
- Error checks (any one sets rsp_err = 1):
  - word index >= DEPTH_WORDS
  - funct3 not in {000, 001, 010, 100, 101} for loads
  - funct3 not in {000, 001, 010} for stores
  - LH/LHU/SH with addr[0] = 1
  - LW/SW with addr[1:0] != 0
- On error: no array write, rsp_rdata = 0.
- Store lane mask:
  - SB: 4'b0001 << addr[1:0]
  - SH: 4'b0011 << {addr[1], 1'b0}
  - SW: 4'b1111
  - The lane mask is ANDed with req_wmask.
- Store data: wdata is replicated per width (byte ×4, half ×2) before the masked write.
- Mask result of 0: no write, no error.
- Load extraction from the addressed word:
  - LB: lane addr[1:0], sign-extend bit 7
  - LBU: same lane, zero-extend
  - LH: half addr[1], sign-extend bit 15
  - LHU: same half, zero-extend
  - LW: full word
- Stores return rsp_rdata = 0.
- Reset mid-operation: a request in WAIT is dropped with no write and no response. A response in RESP is cut, with rsp_valid low on the next cycle. Memory keeps prior contents.
- Address bits above the index width beyond DEPTH are checked, not wrapped.

Test Plan:
- Reset, WAIT_CYCLES=1: hold rst 2 cycles then release → req_ready 0 during rst, 1 on the first cycle after; rsp_valid 0; rsp_rdata 0.
- SW addr 0x10 data 0xDEADBEEF mask 1111, then LW 0x10 → store response rsp_err 0, rdata 0; load rsp_rdata 0xDEADBEEF exactly 2 cycles after its accept edge.
- SB addr 0x13 data 0x000000A5, then LB 0x13 / LBU 0x13 / LW 0x10 → 0xFFFFFFA5 / 0x000000A5 / 0xA5ADBEEF.
- Misaligned/range: LW 0x12 → err 1, rdata 0. SH 0x11 → err 1, word 0x10 unchanged. LW at 4*DEPTH_WORDS → err 1.
- Reset mid-op, WAIT_CYCLES=3: accept SW 0x20 data 0x12345678, assert rst in the 2nd WAIT cycle → no rsp_valid; a later LW 0x20 returns the prior contents.
- WAIT_CYCLES=0, back-to-back req_valid held high for two loads → rsp_valid one cycle after each accept; req_ready low in RESP; 2-cycle request spacing.
